// File: rtl/mmio_peripherals_pkg.sv
// rtl/mmio_peripherals_pkg.sv - shared memory-map defines for the peripheral window
package mmio_peripherals_pkg;

    localparam logic [1:0]  MEM_ROM  = 2'd0;
    localparam logic [1:0]  MEM_RAM  = 2'd1;
    localparam logic [1:0]  MEM_MMIO = 2'd2;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;
    localparam logic [31:0] TIMER_CMP_RESET   = 32'hFFFF_FFFF;

    localparam logic [7:0]  OFF_LED         = 8'h00;
    localparam logic [7:0]  OFF_PHOTO_LEVEL = 8'h04;
    localparam logic [7:0]  OFF_PHOTO_EDGE  = 8'h08;
    localparam logic [7:0]  OFF_TIMER_COUNT = 8'h0C;
    localparam logic [7:0]  OFF_TIMER_CMP   = 8'h10;
    localparam logic [7:0]  OFF_TIMER_STAT  = 8'h14;

endpackage

// File: rtl/photo_debounce.sv
// rtl/photo_debounce.sv - synchroniser and stability debounce for one photoresistor bit
module photo_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while a change is pending and stops at CNT_LAST.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_d & ~level_q;

endmodule

// File: rtl/mmio_peripherals.sv
// rtl/mmio_peripherals.sv - memory-mapped LED, photoresistor and timer registers
module mmio_peripherals
    import mmio_peripherals_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = MMIO_BASE_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  photores,
    output logic [31:0] read_data,
    output logic        hit,
    output logic [4:0]  led
);
    logic        in_win, wr_en, rd_en;
    logic [7:0]  offset;
    logic [31:0] rd_val;
    logic [1:0]  photo_level, photo_rise;
    logic        unused_addr_bits;

    logic [4:0]  led_q, led_d;
    logic [1:0]  photo_edge_q, photo_edge_d;
    logic [31:0] timer_count_q, timer_count_d;
    logic [31:0] timer_cmp_q, timer_cmp_d;
    logic        timer_stat_q, timer_stat_d;
    logic [31:0] read_data_q, read_data_d;
    logic        hit_q, hit_d;

    assign in_win           = address[31:8] == BASE_ADDR[31:8];
    assign offset           = {address[7:2], 2'b00};
    assign wr_en            = in_win & mem_write;
    assign rd_en            = in_win & mem_read;
    assign unused_addr_bits = ^address[1:0];

    for (genvar i = 0; i < 2; i++) begin : g_photo
        photo_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (clock),
            .reset_n(reset_n),
            .raw    (photores[i]),
            .level  (photo_level[i]),
            .rise   (photo_rise[i])
        );
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_LED:         rd_val = {27'd0, led_q};
            OFF_PHOTO_LEVEL: rd_val = {30'd0, photo_level};
            OFF_PHOTO_EDGE:  rd_val = {30'd0, photo_edge_q};
            OFF_TIMER_COUNT: rd_val = timer_count_q;
            OFF_TIMER_CMP:   rd_val = timer_cmp_q;
            OFF_TIMER_STAT:  rd_val = {31'd0, timer_stat_q};
            default:         rd_val = '0;
        endcase
    end

    // Reads sample pre-edge state, so a same-cycle store is invisible to the load.
    always_comb begin
        led_d         = led_q;
        photo_edge_d  = photo_edge_q;
        timer_count_d = timer_count_q + 32'd1;
        timer_cmp_d   = timer_cmp_q;
        timer_stat_d  = timer_stat_q;
        read_data_d   = rd_en ? rd_val : '0;
        hit_d         = in_win & (mem_read | mem_write);
        if (wr_en) begin
            case (offset)
                OFF_LED:         led_d = write_data[4:0];
                OFF_PHOTO_EDGE:  photo_edge_d = photo_edge_q & ~write_data[1:0];
                OFF_TIMER_COUNT: timer_count_d = write_data;
                OFF_TIMER_CMP:   timer_cmp_d = write_data;
                OFF_TIMER_STAT:  if (write_data[0]) timer_stat_d = 1'b0;
                default:         ;
            endcase
        end
        // Hardware set events override software clears in the same cycle.
        photo_edge_d = photo_edge_d | photo_rise;
        if (timer_count_q == timer_cmp_q) begin
            timer_stat_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            led_q         <= '0;
            photo_edge_q  <= '0;
            timer_count_q <= '0;
            timer_cmp_q   <= TIMER_CMP_RESET;
            timer_stat_q  <= 1'b0;
            read_data_q   <= '0;
            hit_q         <= 1'b0;
        end else begin
            led_q         <= led_d;
            photo_edge_q  <= photo_edge_d;
            timer_count_q <= timer_count_d;
            timer_cmp_q   <= timer_cmp_d;
            timer_stat_q  <= timer_stat_d;
            read_data_q   <= read_data_d;
            hit_q         <= hit_d;
        end
    end

    assign read_data = read_data_q;
    assign hit       = hit_q;
    assign led       = ~led_q;

endmodule
